// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and request/acknowledge sequencer for the shared memory port.
// Grants A or B, steers the shared 2:1 muxes and aborts an access after MAX_WAIT cycles.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_a,
    input  logic req_b,
    input  logic mem_ack,
    output logic mem_sel,
    output logic mem_req,
    output logic ack_a,
    output logic ack_b,
    output logic err_a,
    output logic err_b,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    state_t     state_q, state_d;
    logic       mem_sel_q, mem_sel_d;
    logic       mem_req_q, mem_req_d;
    logic       ack_a_q, ack_a_d;
    logic       ack_b_q, ack_b_d;
    logic       err_a_q, err_a_d;
    logic       err_b_q, err_b_d;
    logic       busy_q, busy_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] cnt_q, cnt_d;
    logic       winner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mem_sel_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            err_a_q      <= 1'b0;
            err_b_q      <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            mem_sel_q    <= mem_sel_d;
            mem_req_q    <= mem_req_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            err_a_q      <= err_a_d;
            err_b_q      <= err_b_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_sel_d    = mem_sel_q;
        mem_req_d    = mem_req_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        err_a_d      = 1'b0;
        err_b_d      = 1'b0;
        // On a tie the requester not served last wins; otherwise the lone requester.
        winner       = (req_a && req_b) ? ~last_grant_q : req_b;

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    mem_sel_d    = winner;
                    mem_req_d    = 1'b1;
                    last_grant_d = winner;
                    cnt_d        = 8'd0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                // An acknowledge on the final wait cycle still counts as success.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    ack_a_d   = ~mem_sel_q;
                    ack_b_d   = mem_sel_q;
                    state_d   = DONE;
                end else if (cnt_q == LAST_CNT) begin
                    mem_req_d = 1'b0;
                    err_a_d   = ~mem_sel_q;
                    err_b_d   = mem_sel_q;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign mem_sel = mem_sel_q;
    assign mem_req = mem_req_q;
    assign ack_a   = ack_a_q;
    assign ack_b   = ack_b_q;
    assign err_a   = err_a_q;
    assign err_b   = err_b_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants and completion pulses are queued as
// expectations by the stimulus and checked by a monitor on the falling clock edge.
module tb_mem_port_arbiter;

    logic clk;
    logic reset_n;
    logic req_a;
    logic req_b;
    logic mem_ack;
    logic mem_sel;
    logic mem_req;
    logic ack_a;
    logic ack_b;
    logic err_a;
    logic err_b;
    logic busy;

    int total_cnt;
    int bad_cnt;

    // Completion codes: bit0 ack_a, bit1 ack_b, bit2 err_a, bit3 err_b.
    int exp_sel_q[$];
    int exp_done_q[$];
    logic prev_req;

    mem_port_arbiter #(.MAX_WAIT(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req_a   (req_a),
        .req_b   (req_b),
        .mem_ack (mem_ack),
        .mem_sel (mem_sel),
        .mem_req (mem_req),
        .ack_a   (ack_a),
        .ack_b   (ack_b),
        .err_a   (err_a),
        .err_b   (err_b),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Monitor: checks the select on every new grant and every completion pulse.
    always @(negedge clk) begin
        int code;
        int e;
        if (reset_n) begin
            if (mem_req && !prev_req) begin
                if (exp_sel_q.size() == 0) begin
                    check_val("unexpected_grant", 32'(mem_sel), 32'hFFFF);
                end else begin
                    e = exp_sel_q.pop_front();
                    check_val("grant_sel", 32'(mem_sel), 32'(e));
                end
            end
            code = {28'd0, err_b, err_a, ack_b, ack_a};
            if (code != 0) begin
                if (exp_done_q.size() == 0) begin
                    check_val("spurious_pulse", 32'(code), 32'd0);
                end else begin
                    e = exp_done_q.pop_front();
                    check_val("done_code", 32'(code), 32'(e));
                    $display("txn t=%0t sel=%0d code=%0d exp=%0d", $time, mem_sel, code, e);
                end
            end
        end
        prev_req = mem_req;
    end

    // Plays the memory side of one transaction; returns mem_req length, idle gap and busy count.
    task automatic serve(input int ack_cycle, input int drop_cycle,
                         output int n, output int gap, output int bcnt);
        n = 0;
        gap = 0;
        bcnt = 0;
        while (!mem_req && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        if (!mem_req) begin
            check_val("grant_wait", 32'd0, 32'd1);
            return;
        end
        n = 1;
        bcnt = int'(busy);
        for (int i = 0; i < 300; i++) begin
            if (n == ack_cycle) mem_ack = 1'b1;
            if (n == drop_cycle) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            bcnt += int'(busy);
            if (!mem_req) break;
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total_cnt, bad_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gap;
        int bcnt;
        int wait_cnt;

        total_cnt = 0;
        bad_cnt   = 0;
        prev_req  = 1'b0;
        reset_n   = 1'b0;
        req_a     = 1'b1;
        req_b     = 1'b1;
        mem_ack   = 1'b0;

        // Reset state with both requests pending.
        repeat (3) @(negedge clk);
        check_val("rst_outs", {25'd0, mem_sel, mem_req, ack_a, ack_b, err_a, err_b, busy}, 32'd0);

        // Round-robin: A first, then strict alternation, ack in the 2nd busy cycle.
        for (int i = 0; i < 6; i++) begin
            exp_sel_q.push_back(i % 2);
            exp_done_q.push_back((i % 2 == 0) ? 1 : 2);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            serve(2, 0, n, gap, bcnt);
            check_val("rr_len", 32'(n), 32'd2);
            check_val("rr_busy", 32'(bcnt), 32'd3);
            if (i > 0) check_val("rr_gap", 32'(gap), 32'd2);
        end
        req_a = 1'b0;
        req_b = 1'b0;

        // B alone, ack in the first busy cycle.
        repeat (2) @(negedge clk);
        exp_sel_q.push_back(1);
        exp_done_q.push_back(2);
        req_b = 1'b1;
        serve(1, 0, n, gap, bcnt);
        req_b = 1'b0;
        check_val("b_len", 32'(n), 32'd1);
        check_val("b_busy", 32'(bcnt), 32'd2);

        // A with no ack: timeout after MAX_WAIT cycles.
        @(negedge clk);
        exp_sel_q.push_back(0);
        exp_done_q.push_back(4);
        req_a = 1'b1;
        serve(0, 0, n, gap, bcnt);
        req_a = 1'b0;
        check_val("to_len", 32'(n), 32'd15);
        check_val("to_busy", 32'(bcnt), 32'd16);
        @(negedge clk);
        check_val("to_idle", {30'd0, busy, mem_req}, 32'd0);

        // A with ack on the last allowed cycle: ack wins.
        exp_sel_q.push_back(0);
        exp_done_q.push_back(1);
        req_a = 1'b1;
        serve(15, 0, n, gap, bcnt);
        req_a = 1'b0;
        check_val("late_ack_len", 32'(n), 32'd15);

        // A drops req mid-transaction, then spurious acks in DONE and IDLE.
        @(negedge clk);
        exp_sel_q.push_back(0);
        exp_done_q.push_back(1);
        req_a = 1'b1;
        serve(5, 2, n, gap, bcnt);
        check_val("drop_len", 32'(n), 32'd5);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_val("spur_done", {30'd0, busy, mem_req}, 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_val("spur_idle", {30'd0, busy, mem_req}, 32'd0);
        @(negedge clk);
        check_val("spur_idle2", {30'd0, busy, mem_req}, 32'd0);

        // Asynchronous reset in the middle of a B transaction.
        exp_sel_q.push_back(1);
        req_b = 1'b1;
        wait_cnt = 0;
        while (!mem_req && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check_val("b2_grant", 32'(mem_req), 32'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("async_rst", {25'd0, mem_sel, mem_req, ack_a, ack_b, err_a, err_b, busy}, 32'd0);
        @(negedge clk);
        req_a = 1'b1;
        check_val("rst_hold", {25'd0, mem_sel, mem_req, ack_a, ack_b, err_a, err_b, busy}, 32'd0);
        @(negedge clk);
        exp_sel_q.push_back(0);
        exp_done_q.push_back(1);
        reset_n = 1'b1;
        serve(1, 1, n, gap, bcnt);
        check_val("post_rst_len", 32'(n), 32'd1);

        repeat (3) @(negedge clk);
        check_val("sel_q_empty", 32'(exp_sel_q.size()), 32'd0);
        check_val("done_q_empty", 32'(exp_done_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
